// File: rtl/tb_clock_checker_if.sv
// Control, limit and measurement bundle of the clock checker.
// master drives enable/limits/MON_IN and observes results; slave is the checker.
interface tb_clock_checker_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             MON_IN;
  logic             clr_err;
  logic [CNT_W-1:0] min_period;
  logic [CNT_W-1:0] max_period;
  logic [CNT_W-1:0] min_high;
  logic [CNT_W-1:0] max_high;
  logic [CNT_W-1:0] min_low;
  logic [CNT_W-1:0] max_low;
  logic [CNT_W-1:0] timeout;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             err_period;
  logic             err_high;
  logic             err_low;
  logic             err_stuck;
  logic             locked;

  modport master (
    output enable, MON_IN, clr_err,
    output min_period, max_period, min_high, max_high, min_low, max_low, timeout,
    input  high_cnt, low_cnt, period_cnt, meas_valid,
    input  err_period, err_high, err_low, err_stuck, locked
  );

  modport slave (
    input  enable, MON_IN, clr_err,
    input  min_period, max_period, min_high, max_high, min_low, max_low, timeout,
    output high_cnt, low_cnt, period_cnt, meas_valid,
    output err_period, err_high, err_low, err_stuck, locked
  );
endinterface

// File: rtl/tb_clock_checker.sv
// Measures high/low/period of an asynchronous clock in CLK cycles, range-checks
// each completed period, flags stuck inputs and reports lock after clean periods.
module tb_clock_checker #(
  parameter int CNT_W      = 16,
  parameter int LOCK_COUNT = 4
) (
  input logic               CLK,
  input logic               RST_N,
  tb_clock_checker_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               CLEAN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CLEAN_W-1:0] CLEAN_TARGET = CLEAN_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               s1, s2, s3;
  logic               rise, fall;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   high_lat;
  logic               timed_out;
  logic [CLEAN_W-1:0] clean_cnt;

  logic               start_high;
  logic               latch_high;
  logic               publish;
  logic               stuck;
  logic               count_up;

  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   period_sat;
  logic               bad_period, bad_high, bad_low, violation;

  logic [CNT_W-1:0]   high_q, low_q, period_q;
  logic               valid_q, err_period_q, err_high_q, err_low_q, err_stuck_q, locked_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.MON_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign timed_out = (cnt >= bus.timeout);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nxt = WAIT_RISE;
        WAIT_RISE: if (rise) state_nxt = MEAS_HIGH;
        MEAS_HIGH: begin
          if (fall)           state_nxt = MEAS_LOW;
          else if (timed_out) state_nxt = WAIT_RISE;
        end
        MEAS_LOW: begin
          if (rise)           state_nxt = MEAS_HIGH;
          else if (timed_out) state_nxt = WAIT_RISE;
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Only the edge the current state expects is acted on; the other one is ignored.
  always_comb begin
    start_high = 1'b0;
    latch_high = 1'b0;
    publish    = 1'b0;
    stuck      = 1'b0;
    count_up   = 1'b0;
    if (bus.enable) begin
      unique case (state)
        WAIT_RISE: start_high = rise;
        MEAS_HIGH: begin
          latch_high = fall;
          stuck      = ~fall & timed_out;
          count_up   = ~fall & ~timed_out;
        end
        MEAS_LOW: begin
          start_high = rise;
          publish    = rise;
          stuck      = ~rise & timed_out;
          count_up   = ~rise & ~timed_out;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      high_lat <= '0;
    end else begin
      if (!bus.enable || stuck)          cnt <= '0;
      else if (start_high || latch_high) cnt <= CNT_W'(1);
      else if (count_up && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (latch_high) high_lat <= cnt;
    end
  end

  assign sum        = {1'b0, high_lat} + {1'b0, cnt};
  assign period_sat = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  assign bad_period = (period_sat < bus.min_period) || (period_sat > bus.max_period);
  assign bad_high   = (high_lat < bus.min_high) || (high_lat > bus.max_high);
  assign bad_low    = (cnt < bus.min_low) || (cnt > bus.max_low);
  assign violation  = publish & (bad_period | bad_high | bad_low);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= publish;
      if (publish) begin
        high_q   <= high_lat;
        low_q    <= cnt;
        period_q <= period_sat;
      end
    end
  end

  // A new violation in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_period_q <= 1'b0;
      err_high_q   <= 1'b0;
      err_low_q    <= 1'b0;
      err_stuck_q  <= 1'b0;
    end else begin
      err_period_q <= (publish & bad_period) | (err_period_q & ~bus.clr_err);
      err_high_q   <= (publish & bad_high)   | (err_high_q   & ~bus.clr_err);
      err_low_q    <= (publish & bad_low)    | (err_low_q    & ~bus.clr_err);
      err_stuck_q  <= stuck                  | (err_stuck_q  & ~bus.clr_err);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clean_cnt <= '0;
      locked_q  <= 1'b0;
    end else if (!bus.enable || stuck || violation) begin
      clean_cnt <= '0;
      locked_q  <= 1'b0;
    end else if (publish) begin
      if (clean_cnt != CLEAN_TARGET) clean_cnt <= clean_cnt + 1'b1;
      if (clean_cnt >= CLEAN_TARGET - 1'b1) locked_q <= 1'b1;
    end
  end

  assign bus.high_cnt   = high_q;
  assign bus.low_cnt    = low_q;
  assign bus.period_cnt = period_q;
  assign bus.meas_valid = valid_q;
  assign bus.err_period = err_period_q;
  assign bus.err_high   = err_high_q;
  assign bus.err_low    = err_low_q;
  assign bus.err_stuck  = err_stuck_q;
  assign bus.locked     = locked_q;
endmodule

// File: doc/tb_clock_checker.md
TB_CLOCK_CHECKER -- requirements
Module: tb_clock_checker

Interface
REQ-001 Parameter CNT_W, default 16: width of all cycle counters, limits and measured values.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive in-range periods required before lock.
REQ-003 CLK  input  1  sampling clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  1 = monitor running; 0 = return to IDLE.
REQ-006 MON_IN  input  1  monitored clock; asynchronous to CLK.
REQ-007 clr_err  input  1  synchronous clear of sticky error flags.
REQ-008 min_period, max_period  input  CNT_W each  allowed period range, in CLK cycles, inclusive.
REQ-009 min_high, max_high, min_low, max_low  input  CNT_W each  allowed phase ranges, inclusive.
REQ-010 timeout  input  CNT_W  maximum cycles without an edge before stuck is declared.
REQ-011 high_cnt, low_cnt, period_cnt  output  CNT_W each  last completed measurement.
REQ-012 meas_valid  output  1  one-cycle pulse when a new measurement is published.
REQ-013 err_period, err_high, err_low, err_stuck  output  1 each  sticky violation flags.
REQ-014 locked  output  1  LOCK_COUNT consecutive clean periods seen, no error since.

Function
REQ-015 MON_IN shall pass through a two-flop synchronizer (s1, s2) followed by a history flop (s3).
REQ-016 Rise is s2 & ~s3; fall is ~s2 & s3; both are evaluated combinationally in the same cycle.
REQ-017 FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-018 IDLE -> WAIT_RISE when enable=1; any state -> IDLE when enable=0, with outputs holding their values.
REQ-019 WAIT_RISE -> MEAS_HIGH on rise; the partial phase before the first rise is discarded.
REQ-020 MEAS_HIGH: phase counter loads 1 on entry and increments each cycle; on fall, latch high count and go to MEAS_LOW with the counter at 1.
REQ-021 MEAS_LOW: counter increments each cycle; on rise, publish the measurement and go to MEAS_HIGH with the counter at 1.
REQ-022 Publishing:
  - high_cnt = latched high count; low_cnt = counter; period_cnt = high + low, saturated at 2^CNT_W-1.
  - meas_valid pulses 1 cycle, registered, in the cycle after the rise.
REQ-023 Phase counters shall saturate at 2^CNT_W-1 and never wrap.
REQ-024 Range checks on each publish:
  - err_period set if period_cnt is outside [min_period, max_period].
  - err_high set if high_cnt is outside [min_high, max_high].
  - err_low set if low_cnt is outside [min_low, max_low].
REQ-025 In MEAS_HIGH or MEAS_LOW, when the counter reaches timeout without an edge:
  - set err_stuck;
  - clear locked;
  - go to WAIT_RISE.
REQ-026 A clean-period counter increments on each in-range publish and resets to 0 on any violation.
REQ-027 locked asserts when the clean-period counter reaches LOCK_COUNT and holds until a violation, stuck, enable=0 or reset.
REQ-028 clr_err clears all err_* flags next cycle; if a violation occurs in the same cycle, the set wins.
REQ-029 The first publish after WAIT_RISE shall be a complete high+low period; no publish from WAIT_RISE.
REQ-030 If rise and fall are both seen within one cycle because of synchronizer aliasing, only the current state's expected edge is acted on.

Reset
REQ-031 On RST_N=0, all flops clear immediately:
  - FSM to IDLE;
  - counters, high_cnt, low_cnt, period_cnt = 0;
  - meas_valid, err_*, locked = 0;
  - s1, s2, s3 = 0.
REQ-032 Reset mid-measurement discards the partial measurement; after release, the block restarts from IDLE.

Verification
REQ-033 Setup: enable=1, MON_IN 4 high / 6 low, limits period 8..12, high 3..5, low 5..7.
  - Response: high_cnt=4, low_cnt=6, period_cnt=10, meas_valid every 10 cycles, no errors, locked after the 4th publish.
REQ-034 After lock, change MON_IN to 4 high / 10 low.
  - Response: period_cnt=14, err_period=1, err_low=1, locked=0 in the publish cycle; flags persist until clr_err.
REQ-035 Setup: timeout=20, MON_IN held high for 30 cycles.
  - Response: err_stuck=1 at counter=20, locked=0, FSM to WAIT_RISE; next publish only after a full new period.
REQ-036 Assert RST_N=0 mid MEAS_LOW.
  - Response: all outputs 0 asynchronously; after release with a clean clock, the first meas_valid follows one complete period plus synchronizer latency.
REQ-037 Pulse clr_err in the same cycle as an out-of-range publish.
  - Response: the flag stays 1; a clr_err pulse on the next cycle clears it.
REQ-038 Set CNT_W=4, MON_IN high for 20 cycles, timeout=15.
  - Response: the counter saturates at 15 and never wraps; err_stuck=1.
